// File: rtl/riscv_pkg.sv
// Constants and instruction encoders shared between the fetch queue and the pipelined core.
package riscv_pkg;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] EOF = 32'hFFFF_FFFF;

    localparam logic [6:0] LW    = 7'b000_0011;
    localparam logic [6:0] SW    = 7'b010_0011;
    localparam logic [6:0] BEQ   = 7'b110_0011;
    localparam logic [6:0] ALUop = 7'b011_0011;
    localparam logic [6:0] ADDI  = 7'b001_0011;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] make_addi(input logic [4:0]  rd,
                                              input logic [4:0]  rs1,
                                              input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, ADDI};
    endfunction

    function automatic logic [31:0] make_lw(input logic [4:0]  rd,
                                            input logic [4:0]  rs1,
                                            input logic [11:0] imm);
        return {imm, rs1, 3'b010, rd, LW};
    endfunction

    function automatic logic [31:0] make_sw(input logic [4:0]  rs2,
                                            input logic [4:0]  rs1,
                                            input logic [11:0] imm);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], SW};
    endfunction

    // Branch offsets are always even, so bit 0 is not carried.
    function automatic logic [31:0] make_beq(input logic [4:0]  rs1,
                                             input logic [4:0]  rs2,
                                             input logic [12:1] imm);
        return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], BEQ};
    endfunction

    function automatic logic [31:0] make_alu(input logic [6:0] funct7,
                                             input logic [4:0] rs2,
                                             input logic [4:0] rs1,
                                             input logic [2:0] funct3,
                                             input logic [4:0] rd);
        return {funct7, rs2, rs1, funct3, rd, ALUop};
    endfunction

    function automatic logic is_eof(input logic [31:0] instr);
        return instr == EOF;
    endfunction

endpackage

// File: rtl/fifo_sync.sv
// Synchronous FIFO with flush; the head entry is read combinationally at the read pointer.
module fifo_sync #(
    parameter int unsigned Width = 64,
    parameter int unsigned Depth = 4
) (
    input  logic                   CLOCK_50,
    input  logic                   rstn,
    input  logic                   push_i,
    input  logic [Width-1:0]       push_data_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output logic [$clog2(Depth):0] count_o,
    output logic [Width-1:0]       head_o
);

    localparam int unsigned PtrW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW:0]    count_q, count_d;
    logic             do_push, do_pop;

    // Depth is a power of two, so the count MSB alone marks a full FIFO.
    assign do_push = push_i && !flush_i && !count_q[PtrW];
    assign do_pop  = pop_i && (count_q != '0);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count_d = count_q + (PtrW + 1)'(1);
                2'b01:   count_d = count_q - (PtrW + 1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!rstn) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/ifetch_queue.sv
// Instruction prefetch queue: fetches from a 1-cycle-latency RAM into a small FIFO,
// with redirect flush, EOF / end-of-RAM stop and credit-based flow control.
module ifetch_queue
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned IMEM_WORDS = 56,
    parameter int unsigned IDX_W      = 6
) (
    input  logic             CLOCK_50,
    input  logic             rstn,
    output logic [IDX_W-1:0] imem_index,
    output logic             imem_rd_en,
    input  logic [31:0]      imem_data,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [31:0]      out_pc,
    output logic             eof_seen,
    output logic [31:0]      fetch_count
);

    logic [31:0] pc_q, pc_d;
    logic        in_flight_q, in_flight_d;
    logic [31:0] in_flight_pc_q, in_flight_pc_d;
    logic        eof_q, eof_d;
    logic [31:0] fetch_count_q, fetch_count_d;

    logic                  kill, push, pop, fetch;
    logic                  eof_hit, pc_past_end, credit_ok;
    logic [$clog2(DEPTH):0] count;
    fetch_entry_t          push_entry, head_entry;

    // The response landing in a redirect cycle belongs to the old path.
    assign kill        = in_flight_q && redirect_valid;
    assign push        = in_flight_q && !kill;
    assign eof_hit     = push && is_eof(imem_data);
    assign pc_past_end = ({2'b00, pc_q[31:2]} >= 32'(IMEM_WORDS));
    assign credit_ok   = (32'(count) + 32'(in_flight_q)) < DEPTH;

    // A word about to be pushed as EOF already stops the next fetch.
    assign fetch = rstn && !redirect_valid && !eof_q && !eof_hit && !pc_past_end && credit_ok;

    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;

    assign push_entry = '{pc: in_flight_pc_q, instr: imem_data};

    always_comb begin
        pc_d           = pc_q;
        eof_d          = eof_q;
        in_flight_d    = fetch;
        in_flight_pc_d = in_flight_pc_q;
        fetch_count_d  = fetch_count_q;
        if (push) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end
        if (fetch) begin
            in_flight_pc_d = pc_q;
            pc_d           = pc_q + 32'd4;
        end
        if (redirect_valid) begin
            pc_d  = redirect_pc & ~32'h3;
            eof_d = 1'b0;
        end else if (eof_hit || pc_past_end) begin
            eof_d = 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!rstn) begin
            pc_q           <= '0;
            in_flight_q    <= 1'b0;
            in_flight_pc_q <= '0;
            eof_q          <= 1'b0;
            fetch_count_q  <= '0;
        end else begin
            pc_q           <= pc_d;
            in_flight_q    <= in_flight_d;
            in_flight_pc_q <= in_flight_pc_d;
            eof_q          <= eof_d;
            fetch_count_q  <= fetch_count_d;
        end
    end

    fifo_sync #(
        .Width ($bits(fetch_entry_t)),
        .Depth (DEPTH)
    ) u_fifo (
        .CLOCK_50    (CLOCK_50),
        .rstn        (rstn),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .flush_i     (redirect_valid),
        .count_o     (count),
        .head_o      (head_entry)
    );

    assign imem_index  = pc_q[IDX_W+1:2];
    assign imem_rd_en  = fetch;
    assign out_instr   = out_valid ? head_entry.instr : NOP;
    assign out_pc      = out_valid ? head_entry.pc : 32'd0;
    assign eof_seen    = eof_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4: prefetch FIFO entries, power of two, at least 2.
REQ-002 SHALL have parameter IMEM_WORDS, default 56: instruction RAM size in 32-bit words.
REQ-003 SHALL have parameter IDX_W, default 6: RAM word-index width, with 2^IDX_W >= IMEM_WORDS.
REQ-004 SHALL have port CLOCK_50, input, 1: clock; all state updates on its rising edge.
REQ-005 SHALL have port rstn, input, 1: reset, synchronous, active-low.
REQ-006 SHALL have port imem_index, output, IDX_W: instruction RAM word index, equal to PC[IDX_W+1:2].
REQ-007 SHALL have port imem_rd_en, output, 1: fetch issued this cycle.
REQ-008 SHALL have port imem_data, input, 32: RAM read data, valid exactly 1 cycle after imem_rd_en.
REQ-009 SHALL have port redirect_valid, input, 1: taken branch or jump from EX; single-cycle pulse.
REQ-010 SHALL have port redirect_pc, input, 32: branch target; bits [1:0] are ignored and treated as 0.
REQ-011 SHALL have port out_valid, output, 1: FIFO head is valid.
REQ-012 SHALL have port out_ready, input, 1: decode stage accepts the head.
REQ-013 SHALL have port out_instr, output, 32: head instruction; NOP 32'h0000_0013 when out_valid=0.
REQ-014 SHALL have port out_pc, output, 32: byte address of the head instruction.
REQ-015 SHALL have port eof_seen, output, 1: EOF word fetched or end of RAM reached; fetching stopped.
REQ-016 SHALL have port fetch_count, output, 32: number of instructions pushed into the FIFO since reset.

Function
REQ-017 SHALL issue a fetch (imem_rd_en=1) when all of the following hold: redirect_valid=0, eof_seen=0, and count + in_flight < DEPTH. The issued fetch SHALL latch the current PC as in_flight_pc and advance PC by 4.
REQ-018 SHALL push {in_flight_pc, imem_data} one cycle after an issued fetch, unless that fetch was killed; each push SHALL increment fetch_count.
REQ-019 SHALL pop the head on out_valid && out_ready; push and pop in the same cycle SHALL leave count unchanged.
REQ-020 SHALL never overflow: the credit rule in REQ-017 guarantees space; out_valid = (count != 0).
REQ-021 SHALL, on redirect_valid:
  - complete any same-cycle pop normally;
  - flush all remaining entries (count=0 next cycle);
  - kill any in-flight response, which is then not pushed and not counted;
  - load PC with {redirect_pc[31:2],2'b00};
  - clear eof_seen;
  - issue no fetch that cycle.
REQ-022 SHALL issue the first post-redirect fetch in the cycle after redirect; minimum redirect-to-out_valid latency is 2 cycles.
REQ-023 SHALL, on a pushed word equal to 32'hFFFF_FFFF: push it normally, set eof_seen the next cycle, and issue no further fetches until a redirect.
REQ-024 SHALL set eof_seen and issue no fetch when PC[31:2] >= IMEM_WORDS.
REQ-025 SHALL, on a redirect in the same cycle as an EOF response: flush per REQ-021 and leave eof_seen=0 (redirect wins).
REQ-026 SHALL wrap FIFO read and write pointers modulo DEPTH.
REQ-027 SHALL hold contents and PC unchanged while out_ready=0 and the FIFO is full; imem_rd_en SHALL be 0 in that state.

Reset
REQ-028 SHALL, while rstn=0 at a clock edge, set: PC=0, count=0, pointers=0, in_flight=0, eof_seen=0, fetch_count=0, imem_rd_en=0, out_valid=0, out_instr=NOP, out_pc=0.
REQ-029 SHALL reset over any in-progress fetch or pending redirect; the in-flight response SHALL be discarded.
REQ-030 SHALL issue its first fetch (PC=0) in the first cycle with rstn=1.

Structure
REQ-031 SHALL take NOP, EOF and the opcode constants (LW, SW, BEQ, ALUop, ADDI) from shared package riscv_pkg, shared with the pipelined core.
REQ-032 SHALL implement FIFO storage as sub-module fifo_sync, parameterised for width and depth, with push/pop/flush, count, and head outputs.
REQ-033 SHALL hold all fetch-control state in the top module: PC, in_flight, kill flag, eof_seen.

Verification
REQ-034 SHALL test streaming: out_ready=1, RAM words 0..5 = distinct ADDIs -> six pops in order with out_pc 0,4,..,20; fetch_count=6 after 7 cycles.
REQ-035 SHALL test backpressure: out_ready=0 for 10 cycles -> count=4, imem_rd_en=0 after 4 fetches, out_pc=0 held; release -> pops 0,4,8,12,16 with no gaps.
REQ-036 SHALL test redirect: redirect to 0x11 with one fetch in flight -> killed word absent, next out_pc=0x10 two cycles later, fetch_count excludes the killed word.
REQ-037 SHALL test EOF: word 3 = 32'hFFFF_FFFF -> EOF popped at out_pc=12, eof_seen=1, no imem_rd_en afterwards; redirect to 0 -> eof_seen=0, fetching resumes.
REQ-038 SHALL test end of RAM: IMEM_WORDS=8 with no EOF word -> last out_pc=28, eof_seen=1.
REQ-039 SHALL test mid-run reset: rstn=0 for 1 cycle while full -> all outputs reset per REQ-028; first fetch at index 0.
